// File: rtl/smg_pkg.sv
// smg_pkg: 7-segment glyph table and bit positions shared by the scan controller.
package smg_pkg;
    localparam int DP_BIT = 7;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    // {g,f,e,d,c,b,a} active-high glyphs for hex 0..F
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
endpackage

// File: rtl/smg_seg_encode.sv
// smg_seg_encode: nibble + blank + dp to active-high {dp,g..a} segment pattern.
module smg_seg_encode
    import smg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    input  logic       i_dp,
    output logic [7:0] o_seg
);
    assign o_seg = {i_dp, i_blank ? SEG_BLANK : GLYPH[i_nib]};
endmodule

// File: rtl/smg_scan_module.sv
// smg_scan_module: multiplexed 7-segment scan with frame snapshot, zero blanking,
// per-digit dp, PWM brightness and a frame tick; outputs carry one clock of latency.
module smg_scan_module
    import smg_pkg::*;
#(
    parameter int N_DIGITS   = 6,
    parameter int T_SLOT     = 50000,
    parameter int BRIGHT_W   = 3,
    parameter int SEL_ACT_LO = 1,
    parameter int SEG_ACT_LO = 1
)(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    En,
    input  logic [4*N_DIGITS-1:0]   Number_Sig,
    input  logic [N_DIGITS-1:0]     Dp_Sig,
    input  logic                    Blank_Lz,
    input  logic [BRIGHT_W-1:0]     Bright,
    output logic [N_DIGITS-1:0]     Scan_Sel,
    output logic [7:0]              Seg_Out,
    output logic [3:0]              Number_Data,
    output logic                    Frame_Tick
);
    localparam int CW = $clog2(T_SLOT);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] C_LAST = CW'(T_SLOT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0] STEP = CW'(T_SLOT >> BRIGHT_W);
    localparam logic [N_DIGITS-1:0] SEL_OFF = (SEL_ACT_LO != 0) ? '1 : '0;
    localparam logic [7:0] SEG_OFF = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;

    logic [CW-1:0]         r_c1;
    logic [IW-1:0]         r_idx;
    logic [4*N_DIGITS-1:0] r_num;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_mask;
    logic [CW-1:0]         r_thr;
    logic                  r_full;

    logic                  w_fs;
    logic                  w_last;
    logic                  w_on;
    logic                  w_run;
    logic [4*N_DIGITS-1:0] w_num;
    logic [N_DIGITS-1:0]   w_dp;
    logic [N_DIGITS-1:0]   w_mask;
    logic [N_DIGITS-1:0]   w_lz;
    logic [N_DIGITS-1:0]   w_dpr;
    logic [N_DIGITS-1:0]   w_sel;
    logic [CW-1:0]         w_thr;
    logic                  w_full;
    logic [3:0]            w_digs [N_DIGITS];
    logic [3:0]            w_nib;
    logic [7:0]            w_seg;

    assign w_last = r_c1 == C_LAST;
    assign w_fs   = En && r_idx == '0 && r_c1 == '0;
    // On the frame-start cycle the live inputs feed the output path directly so
    // digit 0 already shows the values being captured into the shadow registers.
    assign w_num  = w_fs ? Number_Sig : r_num;
    assign w_dp   = w_fs ? Dp_Sig : r_dp;
    assign w_mask = w_fs ? w_lz : r_mask;
    assign w_thr  = w_fs ? STEP * CW'(Bright) : r_thr;
    assign w_full = w_fs ? &Bright : r_full;

    always_comb begin
        w_lz  = '0;
        w_dpr = '0;
        w_run = Blank_Lz;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_digs[i] = w_num[4*(N_DIGITS-1-i) +: 4];
            w_dpr[i]  = w_dp[N_DIGITS-1-i];
        end
        for (int i = 0; i < N_DIGITS - 1; i++) begin
            w_run   = w_run && Number_Sig[4*(N_DIGITS-1-i) +: 4] == 4'h0;
            w_lz[i] = w_run;
        end
    end

    assign w_nib = w_digs[r_idx];
    assign w_sel = N_DIGITS'(1) << r_idx;
    assign w_on  = En && (w_full || r_c1 < w_thr) && !w_last;

    smg_seg_encode u_enc (
        .i_nib   (w_nib),
        .i_blank (w_mask[r_idx]),
        .i_dp    (w_dpr[r_idx]),
        .o_seg   (w_seg)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_c1   <= '0;
            r_idx  <= '0;
            r_num  <= '0;
            r_dp   <= '0;
            r_mask <= '0;
            r_thr  <= '0;
            r_full <= 1'b0;
        end else begin
            r_c1  <= (!En || w_last) ? '0 : r_c1 + 1'b1;
            r_idx <= !En ? '0 : w_last ? (r_idx == I_LAST ? '0 : r_idx + 1'b1) : r_idx;
            if (w_fs) begin
                r_num  <= Number_Sig;
                r_dp   <= Dp_Sig;
                r_mask <= w_lz;
                r_thr  <= w_thr;
                r_full <= w_full;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Scan_Sel    <= SEL_OFF;
            Seg_Out     <= SEG_OFF;
            Number_Data <= 4'h0;
            Frame_Tick  <= 1'b0;
        end else begin
            Scan_Sel    <= w_on ? ((SEL_ACT_LO != 0) ? ~w_sel : w_sel) : SEL_OFF;
            Seg_Out     <= w_on ? ((SEG_ACT_LO != 0) ? ~w_seg : w_seg) : SEG_OFF;
            Number_Data <= En ? w_nib : 4'h0;
            Frame_Tick  <= w_fs;
        end
    end
endmodule

// File: tb/tb_smg_scan_module.sv
// tb_smg_scan_module: directed checks of scan order, blanking, dp, brightness,
// tearing-free snapshot, reset and enable behaviour for a 4-digit, 16-clock-slot build.
module tb_smg_scan_module;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        En = 1'b1;
    logic [15:0] Number_Sig = 16'h1234;
    logic [3:0]  Dp_Sig = 4'b0000;
    logic        Blank_Lz = 1'b0;
    logic [2:0]  Bright = 3'd7;
    logic [3:0]  Scan_Sel;
    logic [7:0]  Seg_Out;
    logic [3:0]  Number_Data;
    logic        Frame_Tick;
    int          total = 0;
    int          bad = 0;
    int          lit;

    smg_scan_module #(
        .N_DIGITS(4), .T_SLOT(16), .BRIGHT_W(3), .SEL_ACT_LO(1), .SEG_ACT_LO(1)
    ) dut (
        .CLK(CLK), .RST(RST), .En(En), .Number_Sig(Number_Sig), .Dp_Sig(Dp_Sig),
        .Blank_Lz(Blank_Lz), .Bright(Bright), .Scan_Sel(Scan_Sel), .Seg_Out(Seg_Out),
        .Number_Data(Number_Data), .Frame_Tick(Frame_Tick)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Advance until the registered frame tick is seen (frame offset 0 displayed).
    task automatic sync();
        int k = 0;
        do begin
            go(1);
            k++;
        end while (!Frame_Tick && k < 200);
        chk("sync_tick", {15'd0, Frame_Tick}, 16'd1);
    endtask

    initial begin
        go(3);
        chk("rst_sel", {12'd0, Scan_Sel}, 16'h000F);
        chk("rst_seg", {8'd0, Seg_Out}, 16'h00FF);
        chk("rst_nd", {12'd0, Number_Data}, 16'h0000);
        chk("rst_tick", {15'd0, Frame_Tick}, 16'd0);
        RST = 1'b0;
        go(1);
        chk("f0_tick", {15'd0, Frame_Tick}, 16'd1);
        chk("f0_sel", {12'd0, Scan_Sel}, 16'h000E);
        chk("f0_seg1", {8'd0, Seg_Out}, 16'h00F9);
        chk("f0_nd", {12'd0, Number_Data}, 16'h0001);
        go(1);
        chk("f1_tick", {15'd0, Frame_Tick}, 16'd0);
        go(13);
        chk("off14_sel", {12'd0, Scan_Sel}, 16'h000E);
        go(1);
        chk("ghost_sel", {12'd0, Scan_Sel}, 16'h000F);
        chk("ghost_seg", {8'd0, Seg_Out}, 16'h00FF);
        go(1);
        chk("d1_sel", {12'd0, Scan_Sel}, 16'h000D);
        chk("d1_seg2", {8'd0, Seg_Out}, 16'h00A4);
        chk("d1_nd", {12'd0, Number_Data}, 16'h0002);
        go(16);
        chk("d2_sel", {12'd0, Scan_Sel}, 16'h000B);
        chk("d2_seg3", {8'd0, Seg_Out}, 16'h00B0);
        Number_Sig = 16'h5678;
        go(16);
        chk("d3_sel", {12'd0, Scan_Sel}, 16'h0007);
        chk("tear_seg4", {8'd0, Seg_Out}, 16'h0099);
        chk("tear_nd4", {12'd0, Number_Data}, 16'h0004);
        go(16);
        chk("f2_tick", {15'd0, Frame_Tick}, 16'd1);
        chk("new_seg5", {8'd0, Seg_Out}, 16'h0092);
        go(48);
        chk("new_seg8", {8'd0, Seg_Out}, 16'h0080);
        Bright = 3'd2;
        sync();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) go(1);
            if (Scan_Sel != 4'hF) lit++;
        end
        chk("bright2_lit", lit[15:0], 16'd4);
        Bright = 3'd0;
        sync();
        lit = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) go(1);
            if (Scan_Sel != 4'hF) lit++;
        end
        chk("bright0_lit", lit[15:0], 16'd0);
        Bright = 3'd7;
        Blank_Lz = 1'b1;
        Number_Sig = 16'h0030;
        sync();
        chk("lz_d0", {8'd0, Seg_Out}, 16'h00FF);
        chk("lz_d0_sel", {12'd0, Scan_Sel}, 16'h000E);
        go(16);
        chk("lz_d1", {8'd0, Seg_Out}, 16'h00FF);
        go(16);
        chk("lz_d2", {8'd0, Seg_Out}, 16'h00B0);
        go(16);
        chk("lz_d3", {8'd0, Seg_Out}, 16'h00C0);
        Number_Sig = 16'h0000;
        sync();
        chk("z_d0", {8'd0, Seg_Out}, 16'h00FF);
        go(32);
        chk("z_d2", {8'd0, Seg_Out}, 16'h00FF);
        go(16);
        chk("z_d3", {8'd0, Seg_Out}, 16'h00C0);
        Dp_Sig = 4'b0100;
        Number_Sig = 16'h0005;
        sync();
        chk("dp_d0", {8'd0, Seg_Out}, 16'h00FF);
        go(16);
        chk("dp_d1", {8'd0, Seg_Out}, 16'h007F);
        go(32);
        chk("dp_d3", {8'd0, Seg_Out}, 16'h0092);
        sync();
        go(39);
        chk("pre_rst_sel", {12'd0, Scan_Sel}, 16'h000B);
        RST = 1'b1;
        #1;
        chk("arst_sel", {12'd0, Scan_Sel}, 16'h000F);
        chk("arst_seg", {8'd0, Seg_Out}, 16'h00FF);
        chk("arst_nd", {12'd0, Number_Data}, 16'h0000);
        go(1);
        chk("arst_hold", {12'd0, Scan_Sel}, 16'h000F);
        RST = 1'b0;
        go(1);
        chk("rel_tick", {15'd0, Frame_Tick}, 16'd1);
        chk("rel_sel", {12'd0, Scan_Sel}, 16'h000E);
        go(20);
        En = 1'b0;
        go(1);
        chk("en0_sel", {12'd0, Scan_Sel}, 16'h000F);
        chk("en0_seg", {8'd0, Seg_Out}, 16'h00FF);
        go(10);
        chk("en0_tick", {15'd0, Frame_Tick}, 16'd0);
        chk("en0_sel2", {12'd0, Scan_Sel}, 16'h000F);
        En = 1'b1;
        go(1);
        chk("en1_tick", {15'd0, Frame_Tick}, 16'd1);
        chk("en1_sel", {12'd0, Scan_Sel}, 16'h000E);
        go(16);
        chk("en1_d1_sel", {12'd0, Scan_Sel}, 16'h000D);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
